// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the 256x8 data-memory subsystem: default address and
// data widths and the block-mover state encoding. The memory-side port mux
// imports the same state type so it can decode mover activity consistently.
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mover_state_t;

endpackage

// File: rtl/dmem_block_mover_if.sv
// ---------------------------------------------------------------------------
// dmem_block_mover_if
// Memory-port bundle between the block mover (master) and the data memory /
// system port mux (slave).
//   mem_req      master->slave  mover claims the memory port
//   mem_addr     master->slave  byte address
//   mem_wr_en    master->slave  write enable
//   mem_dat_in   master->slave  write data
//   mem_dat_out  slave->master  combinational read data at mem_addr
// ---------------------------------------------------------------------------
interface dmem_block_mover_if
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dat_in;
    logic [DW-1:0] mem_dat_out;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wr_en,
        output mem_dat_in,
        input  mem_dat_out
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_dat_in,
        output mem_dat_out
    );

endinterface

// File: rtl/dmem_chksum.sv
// ---------------------------------------------------------------------------
// dmem_chksum
// XOR accumulator over the bytes written by the block mover.
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset, clears the accumulator
//   clear   in   synchronous clear (a new transfer was accepted)
//   enable  in   fold data into the accumulator this edge
//   data    in   DW byte to fold in
//   chksum  out  DW current accumulator value (registered)
// clear has priority over enable; the two never coincide in the mover, but
// the priority keeps the behaviour defined if they ever do.
// ---------------------------------------------------------------------------
module dmem_chksum
    import dmem_pkg::*;
#(
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] chksum
);

    logic [DW-1:0] acc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (enable) begin
            acc_reg <= acc_reg ^ data;
        end
    end

    assign chksum = acc_reg;

endmodule

// File: rtl/dmem_block_mover.sv
// ---------------------------------------------------------------------------
// dmem_block_mover
// Block-copy engine in front of the 256x8 data memory. On an accepted start it
// copies len bytes from src_addr to dst_addr in ascending order, one read
// cycle and one write cycle per byte, then pulses done for one cycle.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset (aborts any transfer)
//   start     in   one-cycle request, only honoured in IDLE
//   src_addr  in   AW first source address, sampled with start
//   dst_addr  in   AW first destination address, sampled with start
//   len       in   AW byte count, 0 = no transfer
//   busy      out  high while in RD or WR
//   done      out  one-cycle pulse in DONE
//   chksum    out  DW running XOR of copied bytes (DMEM_MOVER_CHKSUM_EN only)
//   mem       if   master side of dmem_block_mover_if (memory port)
// Build option: define DMEM_MOVER_CHKSUM_EN to add the chksum port and its
// accumulator; otherwise neither exists.
// ---------------------------------------------------------------------------
module dmem_block_mover
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        src_addr,
    input  logic [AW-1:0]        dst_addr,
    input  logic [AW-1:0]        len,
    output logic                 busy,
    output logic                 done,
`ifdef DMEM_MOVER_CHKSUM_EN
    output logic [DW-1:0]        chksum,
`endif
    dmem_block_mover_if.master   mem
);

    mover_state_t  state_reg, state_next;
    logic [AW-1:0] src_ptr_reg, src_ptr_next;
    logic [AW-1:0] dst_ptr_reg, dst_ptr_next;
    logic [AW-1:0] count_reg, count_next;
    logic [DW-1:0] data_reg, data_next;

    // State and datapath registers. Reset returns everything to zero so an
    // aborted transfer leaves no stale pointers behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            count_reg   <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            src_ptr_reg <= src_ptr_next;
            dst_ptr_reg <= dst_ptr_next;
            count_reg   <= count_next;
            data_reg    <= data_next;
        end
    end

    // Next-state and datapath update. Pointers are plain AW-bit adders so
    // they wrap from the top of memory to 0 without any special handling.
    always_comb begin
        state_next   = state_reg;
        src_ptr_next = src_ptr_reg;
        dst_ptr_next = dst_ptr_reg;
        count_next   = count_reg;
        data_next    = data_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_ptr_next = src_addr;
                    dst_ptr_next = dst_addr;
                    count_next   = len;
                    state_next   = (len == '0) ? DONE : RD;
                end
            end
            RD: begin
                data_next    = mem.mem_dat_out;
                src_ptr_next = src_ptr_reg + AW'(1);
                state_next   = WR;
            end
            WR: begin
                dst_ptr_next = dst_ptr_reg + AW'(1);
                count_next   = count_reg - AW'(1);
                // Decision uses the pre-decrement value: 1 means this write
                // is the last byte.
                state_next   = (count_reg == AW'(1)) ? DONE : RD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy        = (state_reg == RD) || (state_reg == WR);
    assign done        = (state_reg == DONE);
    assign mem.mem_req = busy;

    // Memory port decoded from registered state only, so it is stable for the
    // whole cycle and parks at zero whenever the mover does not own the port.
    always_comb begin
        mem.mem_addr   = '0;
        mem.mem_wr_en  = 1'b0;
        mem.mem_dat_in = '0;
        case (state_reg)
            RD: begin
                mem.mem_addr = src_ptr_reg;
            end
            WR: begin
                mem.mem_addr   = dst_ptr_reg;
                mem.mem_wr_en  = 1'b1;
                mem.mem_dat_in = data_reg;
            end
            default: begin
                mem.mem_addr   = '0;
                mem.mem_wr_en  = 1'b0;
                mem.mem_dat_in = '0;
            end
        endcase
    end

`ifdef DMEM_MOVER_CHKSUM_EN
    // Cleared on every accepted start (including len 0), folded at each WR
    // edge with the byte being written; holds between transfers.
    logic chk_clear;
    logic chk_en;

    assign chk_clear = (state_reg == IDLE) && start;
    assign chk_en    = (state_reg == WR);

    dmem_chksum #(
        .DW (DW)
    ) u_chksum (
        .clk    (clk),
        .reset  (reset),
        .clear  (chk_clear),
        .enable (chk_en),
        .data   (data_reg),
        .chksum (chksum)
    );
`else
`endif

endmodule
